// File: rtl/r2r_dac_sequencer.sv
// Sample-rate scheduler and waveform sequencer driving the 8-bit R2R DAC code bus.
module r2r_dac_sequencer #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] r2r_out,
  output logic       sample_tick,
  output logic       underrun
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    MODE_EXT = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e                mode_q, mode_d;
  dir_e                 dir_q, dir_d;
  logic                 enable_q, enable_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [7:0]           step_q, step_d;
  logic [7:0]           r2r_d;
  logic                 tick_d;
  logic                 underrun_d;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     fill_q, fill_d;

  logic                 ctrl_wr;
  logic                 fifo_clear;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 tick_int;
  logic                 push;
  logic                 pop;
  logic [8:0]           tri_sum;
  logic [15:0]          div_wide;

  // Next-state logic for config, divider, waveform generator and FIFO pointers
  always_comb begin
    mode_d     = mode_q;
    enable_d   = enable_q;
    div_d      = div_q;
    step_d     = step_q;
    count_d    = count_q;
    dir_d      = dir_q;
    r2r_d      = r2r_out;
    tick_d     = 1'b0;
    underrun_d = underrun;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    div_wide   = 16'(div_q);
    tri_sum    = {1'b0, r2r_out} + {1'b0, step_q};

    ctrl_wr    = cfg_we && (cfg_addr == 2'd0);
    fifo_clear = ctrl_wr && cfg_data[3];
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == CNT_W'(FIFO_DEPTH));
    tick_int   = enable_q && (count_q >= div_q);
    push       = s_valid && !fifo_full && !fifo_clear;
    pop        = tick_int && !ctrl_wr && (mode_q == MODE_EXT) && !fifo_empty;

    // A CTRL write restarts the waveform phase and wins over a coincident tick
    if (ctrl_wr) begin
      mode_d     = mode_e'(cfg_data[1:0]);
      enable_d   = cfg_data[2];
      count_d    = '0;
      r2r_d      = 8'h00;
      dir_d      = DIR_UP;
      underrun_d = 1'b0;
    end else if (!enable_q) begin
      count_d = '0;
    end else if (tick_int) begin
      count_d = '0;
      tick_d  = 1'b1;
      unique case (mode_q)
        MODE_EXT: begin
          if (fifo_empty) underrun_d = 1'b1;
          else            r2r_d      = mem[rd_ptr_q];
        end
        MODE_SAW: r2r_d = r2r_out + step_q;
        MODE_TRI: begin
          if (dir_q == DIR_UP) begin
            r2r_d = tri_sum[8] ? 8'hFF : tri_sum[7:0];
            if (r2r_d == 8'hFF) dir_d = DIR_DOWN;
          end else begin
            r2r_d = (r2r_out < step_q) ? 8'h00 : (r2r_out - step_q);
            if (r2r_d == 8'h00) dir_d = DIR_UP;
          end
        end
        MODE_SQR: r2r_d = (r2r_out == 8'h00) ? 8'hFF : 8'h00;
        default:  r2r_d = r2r_out;
      endcase
    end else begin
      count_d = count_q + DIV_WIDTH'(1);
    end

    if (cfg_we && (cfg_addr == 2'd1)) div_wide[7:0]  = cfg_data;
    if (cfg_we && (cfg_addr == 2'd2)) div_wide[15:8] = cfg_data;
    div_d = DIV_WIDTH'(div_wide);
    if (cfg_we && (cfg_addr == 2'd3)) step_d = cfg_data;

    if (fifo_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fill_d = fill_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_EXT;
      enable_q    <= 1'b0;
      div_q       <= '0;
      step_q      <= 8'h01;
      count_q     <= '0;
      dir_q       <= DIR_UP;
      r2r_out     <= 8'h00;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      enable_q    <= enable_d;
      div_q       <= div_d;
      step_q      <= step_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      r2r_out     <= r2r_d;
      sample_tick <= tick_d;
      underrun    <= underrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  assign s_ready = (fill_q != CNT_W'(FIFO_DEPTH));

endmodule

// File: doc/r2r_dac_sequencer.md
Name: r2r_dac_sequencer

Overview:
- Sample-rate scheduler and waveform sequencer feeding the 8-bit R2R DAC code bus.
- Generates a programmable sample tick from clk and, on each tick, updates the DAC code from one of four sources: buffered external samples, sawtooth, triangle or square.
- Configured through a small byte-wide register port; external samples arrive through a valid/ready stream into a small FIFO.
- Sits between the chip-level pin decode and the analog R2R ladder.

Parameters:
- DIV_WIDTH, 16: width of the sample-rate divider.
- FIFO_DEPTH, 4: external sample buffer depth in entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- rst  in  1  synchronous reset, active high.
- cfg_we  in  1  register write strobe, single cycle.
- cfg_addr  in  2  register select.
- cfg_data  in  8  register write data.
- s_valid  in  1  external sample valid.
- s_data  in  8  external sample code.
- s_ready  out  1  FIFO can accept a sample.
- r2r_out  out  8  DAC code, registered.
- sample_tick  out  1  one-cycle pulse, high in the same cycle r2r_out takes a new value.
- underrun  out  1  sticky flag: EXT-mode tick found the FIFO empty.

Behaviour:
- Registers:
  - addr0 CTRL: [1:0] mode (0 EXT, 1 SAW, 2 TRI, 3 SQR); [2] enable; [3] fifo_clear, self-clearing and not stored.
  - addr1 DIV[7:0].
  - addr2 DIV[15:8]; only the bits below DIV_WIDTH are used.
  - addr3 STEP.
  - Writes take effect on the cycle after cfg_we.
- Reset values: r2r_out=0x00, sample_tick=0, underrun=0, mode=EXT, enable=0, DIV=0, STEP=0x01, FIFO empty, s_ready=1, divider count=0, triangle direction=up. Reset mid-operation drops all FIFO contents.
- Divider:
  - When enable=1, the counter increments each cycle.
  - When count>=DIV: count<=0 and an internal tick fires. Tick period is DIV+1 cycles; DIV=0 gives a tick every cycle.
  - If DIV is lowered below the current count, the next cycle ticks.
  - When enable=0, the counter holds at 0, no ticks occur and r2r_out holds.
- Latency: r2r_out and sample_tick update the cycle after the internal tick, so the first sample_tick arrives DIV+1 cycles after enable rises.
- Any CTRL write resets the phase: count<=0, r2r_out<=0x00, direction<=up. underrun clears on any CTRL write.
- Update rule per tick, by mode:
  - EXT: pop the FIFO head into r2r_out. If the FIFO is empty, hold r2r_out, set underrun and still pulse sample_tick.
  - SAW: r2r_out <= r2r_out+STEP, modulo 256 (wraps).
  - TRI, direction up: r2r_out <= min(r2r_out+STEP, 255); when the result is 255, direction<=down.
  - TRI, direction down: r2r_out <= max(r2r_out-STEP, 0); when the result is 0, direction<=up.
  - TRI with STEP=0: r2r_out holds.
  - SQR: r2r_out toggles between 0x00 and 0xFF; STEP is ignored.
- FIFO:
  - s_ready = not full.
  - A push occurs when s_valid & s_ready, in any mode and whether or not enabled.
  - Push and pop in the same cycle are both honoured when the FIFO is not empty.
  - When empty, a simultaneous push and pop has no bypass: the pop underruns and the pushed sample is stored.
  - When full, s_ready=0 and the producer must hold s_valid/s_data.
  - fifo_clear empties the FIFO the cycle after the write; a push in the same cycle as the clear is dropped.
- Underrun is sticky until a CTRL write or rst.

Test Plan:
- After rst, write DIV=3, STEP=0x10, CTRL=SAW+enable -> sample_tick every 4 cycles; r2r_out 0x10, 0x20, …, 0xF0, 0x00 (wraps after 16 ticks).
- TRI with STEP=0x60, DIV=0 -> r2r_out 0x60, 0xC0, 0xFF, 0x9F, 0x3F, 0x00, 0x60 on consecutive cycles.
- EXT, DIV=1: push 0x11, 0x22, 0x33, 0x44 with the FIFO disabled, checking s_ready=0 after the 4th push. Then enable -> r2r_out 0x11, 0x22, 0x33, 0x44 every 2 cycles. The 5th tick holds 0x44 and sets underrun=1, which stays 1 until a CTRL write.
- Enable with DIV=9, then write DIV=2 when count=5 -> tick on the next cycle, then every 3 cycles.
- Assert rst mid-SAW with the FIFO holding 2 entries -> next cycle r2r_out=0x00, s_ready=1, no sample_tick until re-enabled.
- SQR, DIV=0, then fifo_clear written while FIFO is full -> r2r_out alternates 0xFF/0x00 every cycle, and s_ready=1 the cycle after the clear.
